// File: rtl/div_tick_gen_pkg.sv
// Shared defaults and helpers for the clock-enable generator.
// Widths and reset values used when the top is not overridden.
// clamp_div/tick_ph keep divisor and tick-phase rules in one place.
package div_tick_gen_pkg;

  localparam int          DIV_W_DFLT   = 8;
  localparam int          CNT_W_DFLT   = 2;
  localparam int unsigned DEF_DIV_DFLT = 4;
  localparam int unsigned TICK_PH_DFLT = 1;

  // A zero divisor would stall the phase counter, so it runs as divide-by-1.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  // Tick phase, pulled back into the period when the period is shorter than tp.
  function automatic int unsigned tick_ph(input int unsigned n,
                                          input int unsigned tp = TICK_PH_DFLT);
    return (tp < n) ? tp : n - 1;
  endfunction

endpackage

// File: rtl/div_tick_gen_if.sv
// Control and status bundle of div_tick_gen.
// master drives run/divisor/clear controls, slave returns tick, level and counter.
// All signals are single-cycle qualified on clk; no handshake.
interface div_tick_gen_if
  import div_tick_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT,
  parameter int CNT_W = CNT_W_DFLT
);

  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             cnt_clr;
  logic             tick;
  logic             lvl;
  logic             div_busy;
  logic [CNT_W-1:0] po_cnt;
  logic             cnt_wrap;

  modport master (
    output en, div_val, div_load, cnt_clr,
    input  tick, lvl, div_busy, po_cnt, cnt_wrap
  );

  modport slave (
    input  en, div_val, div_load, cnt_clr,
    output tick, lvl, div_busy, po_cnt, cnt_wrap
  );

endinterface

// File: rtl/div_tick_gen_phase_ctr.sv
// Phase counter with current and pending divisor; new divisors land on period boundaries.
// Latency: div_busy rises the cycle after div_load; apply at end of period (or next cycle when en=0).
// No backpressure: a later div_load simply overwrites the pending divisor.
module div_tick_gen_phase_ctr
  import div_tick_gen_pkg::*;
#(
  parameter int          DIV_W   = DIV_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic [DIV_W-1:0] ph,
  output logic [DIV_W-1:0] n,
  output logic             div_busy
);

  logic [DIV_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             at_end;
  logic             apply;

  // Advance phase, swap in the pending divisor at the boundary, capture new loads.
  always_comb begin
    at_end = (ph_q == n_q - DIV_W'(1));
    // With the counter frozen there is no boundary to wait for, so apply at once.
    apply  = busy_q && (!en || at_end);
    ph_d   = ph_q;
    n_d    = n_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (en) begin
      ph_d = at_end ? '0 : ph_q + DIV_W'(1);
    end
    if (apply) begin
      n_d    = pend_q;
      ph_d   = '0;
      busy_d = 1'b0;
    end
    // A load in the apply cycle queues behind the value being applied.
    if (div_load) begin
      pend_d = DIV_W'(clamp_div(32'(div_val)));
      busy_d = 1'b1;
    end
  end

  // State registers; reset drops any pending divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= '0;
      n_q    <= DIV_W'(DEF_DIV);
      pend_q <= '0;
      busy_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      n_q    <= n_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign ph       = ph_q;
  assign n        = n_q;
  assign div_busy = busy_q;

endmodule

// File: rtl/div_tick_gen.sv
// Clock-enable generator: one tick per N-cycle period, ~50% level, and a tick counter.
// Latency: tick/lvl registered one cycle after the phase; po_cnt steps the cycle after tick.
// No backpressure: en freezes the phase and suppresses ticks, nothing else stalls.
module div_tick_gen
  import div_tick_gen_pkg::*;
#(
  parameter int          DIV_W   = DIV_W_DFLT,
  parameter int          CNT_W   = CNT_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT,
  parameter int unsigned TICK_PH = TICK_PH_DFLT
) (
  input logic           clk,
  input logic           rst,
  div_tick_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0] ph;
  logic [DIV_W-1:0] n;
  logic             div_busy;

  logic             tick_q, tick_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] po_cnt_q, po_cnt_d;
  logic             cnt_wrap_q, cnt_wrap_d;

  div_tick_gen_phase_ctr #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_phase_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .div_val  (bus.div_val),
    .div_load (bus.div_load),
    .ph       (ph),
    .n        (n),
    .div_busy (div_busy)
  );

  // Tick on the phase match, level high for the upper half of the period.
  always_comb begin
    tick_d = bus.en && (32'(ph) == tick_ph(32'(n), TICK_PH));
    lvl_d  = bus.en ? (ph >= (n >> 1)) : lvl_q;
  end

  // Count registered ticks; a clear wins over a coincident tick and hides the wrap.
  always_comb begin
    po_cnt_d   = po_cnt_q;
    cnt_wrap_d = 1'b0;
    if (bus.cnt_clr) begin
      po_cnt_d = '0;
    end else if (tick_q) begin
      po_cnt_d   = po_cnt_q + CNT_W'(1);
      cnt_wrap_d = (po_cnt_q == CNT_MAX);
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= 1'b0;
      lvl_q      <= 1'b0;
      po_cnt_q   <= '0;
      cnt_wrap_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      lvl_q      <= lvl_d;
      po_cnt_q   <= po_cnt_d;
      cnt_wrap_q <= cnt_wrap_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.lvl      = lvl_q;
  assign bus.div_busy = div_busy;
  assign bus.po_cnt   = po_cnt_q;
  assign bus.cnt_wrap = cnt_wrap_q;

endmodule

// File: tb/tb_div_tick_gen.sv
// Bench for div_tick_gen: default-period vector table, hand sequences for
// divisor changes, freeze, clear and reset, then random stimulus against a reference model.
module tb_div_tick_gen;

  localparam int TPH  = 1;
  localparam int DEFN = 4;
  localparam int CMOD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_tick_gen_if #(.DIV_W(8), .CNT_W(2)) bus ();

  div_tick_gen #(
    .DIV_W   (8),
    .CNT_W   (2),
    .DEF_DIV (4),
    .TICK_PH (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;

  // reference model state: divisor, phase of the coming cycle, pending divisor, outputs
  int m_n, m_ph, m_pend, m_busy, m_tick, m_lvl, m_cnt, m_wrap;

  typedef struct {
    logic       en;
    logic       tick;
    logic       lvl;
    logic       busy;
    logic [1:0] cnt;
    logic       wrap;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", name, step_no, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    return 32'({bus.tick, bus.lvl, bus.div_busy, bus.po_cnt, bus.cnt_wrap});
  endfunction

  function automatic logic [31:0] model_pack();
    return 32'((m_tick << 5) | (m_lvl << 4) | (m_busy << 3) | (m_cnt << 1) | m_wrap);
  endfunction

  // One clock edge of the behaviour, written from the rules of the block.
  task automatic model_edge(input int r, input int e, input int v, input int ld, input int clr);
    int tph, nt, nl, nc, nw;
    if (r != 0) begin
      m_n = DEFN; m_ph = 0; m_pend = 0; m_busy = 0;
      m_tick = 0; m_lvl = 0; m_cnt = 0; m_wrap = 0;
      return;
    end
    tph = (TPH < m_n) ? TPH : m_n - 1;
    nt  = (e != 0 && m_ph == tph) ? 1 : 0;
    nl  = (e != 0) ? ((m_ph >= m_n / 2) ? 1 : 0) : m_lvl;
    nw  = 0;
    nc  = m_cnt;
    if (clr != 0) nc = 0;
    else if (m_tick != 0) begin
      nc = (m_cnt + 1) % CMOD;
      nw = (nc == 0) ? 1 : 0;
    end
    if (m_busy != 0 && (e == 0 || m_ph == m_n - 1)) begin
      m_n = m_pend; m_ph = 0; m_busy = 0;
    end else if (e != 0) begin
      m_ph = (m_ph + 1) % m_n;
    end
    if (ld != 0) begin
      m_pend = (v == 0) ? 1 : v;
      m_busy = 1;
    end
    m_tick = nt; m_lvl = nl; m_cnt = nc; m_wrap = nw;
  endtask

  task automatic step(input logic r, input logic e, input int v, input logic ld, input logic clr);
    rst          = r;
    bus.en       = e;
    bus.div_val  = 8'(v);
    bus.div_load = ld;
    bus.cnt_clr  = clr;
    @(posedge clk);
    model_edge(int'(r), int'(e), v, int'(ld), int'(clr));
    step_no++;
    #1;
    check("model", dut_pack(), model_pack());
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_busy_clear(input string name, input int limit);
    int k = 0;
    while (bus.div_busy !== 1'b0 && k < limit) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      k++;
    end
    check(name, 32'(bus.div_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog step=%0d", step_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int tk[$];
    logic [2:0] bsy;
    logic [9:0] seq;
    logic       lvl0;
    logic [1:0] cnt0;
    int first;
    logic found;

    // defaults after release: tick period 4, first tick on the 2nd edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};

    bus.en = 1'b0; bus.div_val = '0; bus.div_load = 1'b0; bus.cnt_clr = 1'b0;

    // 1: reset then default run
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("reset_state", dut_pack(), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, tbl[i].en, 0, 1'b0, 1'b0);
      check("t1_vec", dut_pack(),
            32'({tbl[i].tick, tbl[i].lvl, tbl[i].busy, tbl[i].cnt, tbl[i].wrap}));
    end

    // 2: load 6 at phase 1 under N=4
    run(1);
    step(1'b0, 1'b1, 6, 1'b1, 1'b0);
    tk.delete();
    if (bus.tick === 1'b1) tk.push_back(0);
    bsy[2] = bus.div_busy;
    for (int j = 1; j <= 18; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (j == 1) bsy[1] = bus.div_busy;
      if (j == 2) bsy[0] = bus.div_busy;
      if (bus.tick === 1'b1) tk.push_back(j);
    end
    check("t2_busy", 32'(bsy), 32'b110);
    check("t2_nticks", 32'(tk.size()), 32'd4);
    if (tk.size() == 4) begin
      check("t2_tick1", 32'(tk[1]), 32'd4);
      check("t2_tick2", 32'(tk[2]), 32'd10);
      check("t2_tick3", 32'(tk[3]), 32'd16);
    end

    // 3: divisor 0 behaves as 1, then divisor 5
    step(1'b0, 1'b1, 0, 1'b1, 1'b0);
    wait_busy_clear("t3_apply1", 20);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      check("t3_n1", 32'({bus.tick, bus.lvl}), 32'b11);
    end
    step(1'b0, 1'b1, 5, 1'b1, 1'b0);
    wait_busy_clear("t3_apply5", 20);
    seq = '0;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      seq = {seq[8:0], bus.lvl};
    end
    check("t3_lvl5", 32'(seq), 32'b0011100111);

    // 4: freeze mid-period for 7 cycles, then resume
    run(3);
    lvl0 = bus.lvl;
    cnt0 = bus.po_cnt;
    for (int j = 0; j < 7; j++) begin
      step(1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("t4_frozen", 32'({bus.tick, bus.lvl, bus.po_cnt}), 32'({1'b0, lvl0, cnt0}));
    end
    first = -1;
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (bus.tick === 1'b1 && first < 0) first = j;
    end
    check("t4_resume", 32'(first), 32'd4);
    step(1'b0, 1'b0, 3, 1'b1, 1'b0);
    check("t4_busy_set", 32'(bus.div_busy), 32'd1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("t4_busy_clr", 32'(bus.div_busy), 32'd0);
    tk.delete();
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (bus.tick === 1'b1) tk.push_back(j);
    end
    check("t4_ticks_n3", 32'(tk.size() == 2 ? (tk[0] * 16 + tk[1]) : 0), 32'(2 * 16 + 5));

    // 5: clear coincident with tick at po_cnt=3, then two loads, last wins
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (bus.tick === 1'b1 && bus.po_cnt === 2'd3) found = 1'b1;
    end
    check("t5_reach_cnt3", 32'(found), 32'd1);
    step(1'b0, 1'b1, 0, 1'b0, 1'b1);
    check("t5_clr", 32'({bus.po_cnt, bus.cnt_wrap}), 32'd0);
    step(1'b0, 1'b1, 7, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9, 1'b1, 1'b0);
    wait_busy_clear("t5_apply", 30);
    tk.delete();
    for (int j = 1; j <= 30; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (bus.tick === 1'b1) tk.push_back(j);
    end
    check("t5_period9", 32'(tk.size() >= 3 ? tk[2] - tk[1] : 0), 32'd9);

    // 6: reset while a divisor is pending at phase 2
    for (int j = 0; j < 20 && m_ph != 1; j++) step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3, 1'b1, 1'b0);
    check("t6_busy", 32'(bus.div_busy), 32'd1);
    step(1'b1, 1'b1, 5, 1'b1, 1'b1);
    check("t6_reset", dut_pack(), 32'd0);
    tk.delete();
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b1, 0, 1'b0, 1'b0);
      if (bus.tick === 1'b1) tk.push_back(j);
    end
    check("t6_ticks", 32'(tk.size() == 3 ? (tk[0] * 256 + tk[1] * 16 + tk[2]) : 0),
          32'(1 * 256 + 5 * 16 + 9));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, e, ld, clr;
      int v;
      r   = ($urandom_range(0, 499) == 0);
      e   = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 14) == 0);
      clr = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      step(r, e, v, ld, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
